sfifo_pkt: RTL and testbench

Synchronous packet FIFO: the next-generation of the team's single-clock data FIFO, adding atomic packet commit, abort/rollback, overflow-drop with counting, and programmable almost-full/almost-empty flags. Writers push words tagged with an end-of-packet marker. Readers only ever see complete, committed packets. Sits between SDR framers (packetisers, bursty DSP outputs) and downstream DMA/bus masters that must never observe a partial packet.

---
 rtl/sfifo_pkg.sv | 13 +
 rtl/sfifo_pkt_mem.sv | 22 ++
 rtl/sfifo_pkt.sv | 120 ++++++++++++
 tb/tb_sfifo_pkt.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/sfifo_pkg.sv
// Shared definitions for the packet FIFO: write-side state encoding and depth helper.
package sfifo_pkg;

  typedef enum logic {
    ACCEPT = 1'b0,
    DROP   = 1'b1
  } wstate_t;

  function automatic int flen(input int lgflen);
    return 1 << lgflen;
  endfunction

endpackage

// File: rtl/sfifo_pkt_mem.sv
// Simple dual-port RAM: one synchronous write port, one asynchronous read port.
module sfifo_pkt_mem #(
  parameter int BW     = 16,
  parameter int LGFLEN = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [LGFLEN-1:0] wr_idx,
  input  logic [BW:0]       wr_word,
  input  logic [LGFLEN-1:0] rd_idx,
  output logic [BW:0]       rd_word
);

  logic [BW:0] mem [(1<<LGFLEN)];

  always_ff @(posedge clk) begin
    if (we) mem[wr_idx] <= wr_word;
  end

  assign rd_word = mem[rd_idx];

endmodule

// File: rtl/sfifo_pkt.sv
// Single-clock packet FIFO with atomic commit, abort rollback and overflow drop.
module sfifo_pkt
  import sfifo_pkg::*;
#(
  parameter int BW     = 16,
  parameter int LGFLEN = 4,
  parameter int DCW    = 16
) (
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_wr,
  input  logic [BW-1:0]     i_data,
  input  logic              i_last,
  input  logic              i_abort,
  input  logic [LGFLEN:0]   i_af_level,
  input  logic [LGFLEN:0]   i_ae_level,
  output logic              o_full,
  output logic [LGFLEN:0]   o_space,
  output logic              o_almost_full,
  output logic              o_drop,
  output logic [DCW-1:0]    o_drop_count,
  input  logic              i_rd,
  output logic [BW-1:0]     o_data,
  output logic              o_last,
  output logic              o_empty,
  output logic [LGFLEN:0]   o_fill,
  output logic              o_almost_empty
);

  localparam int              FLEN   = flen(LGFLEN);
  localparam logic [LGFLEN:0] FLEN_P = (LGFLEN+1)'(FLEN);

  function automatic logic [DCW-1:0] sat_inc(input logic [DCW-1:0] v);
    return (&v) ? v : v + DCW'(1);
  endfunction

  wstate_t         state, state_nx;
  logic [LGFLEN:0] wr_addr, cm_addr, rd_addr;
  logic [LGFLEN:0] wr_nx, cm_nx, used;
  logic            drop_nx, mem_we, w_rd;
  logic [BW:0]     head;

  // Status decoded from registered pointers only
  assign used           = wr_addr - rd_addr;
  assign o_full         = (used == FLEN_P);
  assign o_space        = FLEN_P - used;
  assign o_almost_full  = (used >= i_af_level);
  assign o_fill         = cm_addr - rd_addr;
  assign o_empty        = (o_fill == '0);
  assign o_almost_empty = (o_fill <= i_ae_level);
  assign w_rd           = i_rd && !o_empty;

  always_comb begin
    state_nx = state;
    wr_nx    = wr_addr;
    cm_nx    = cm_addr;
    drop_nx  = 1'b0;
    mem_we   = 1'b0;
    if (i_abort) begin
      wr_nx    = cm_addr;
      state_nx = ACCEPT;
    end else begin
      case (state)
        ACCEPT: begin
          if (i_wr && !o_full) begin
            mem_we = 1'b1;
            wr_nx  = wr_addr + 1'b1;
            if (i_last) cm_nx = wr_addr + 1'b1;
          end else if (i_wr) begin
            // Overflow: roll back the partial packet and swallow its tail
            wr_nx = cm_addr;
            if (i_last) drop_nx  = 1'b1;
            else        state_nx = DROP;
          end
        end
        DROP: begin
          if (i_wr && i_last) begin
            drop_nx  = 1'b1;
            state_nx = ACCEPT;
          end
        end
        default: state_nx = ACCEPT;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state        <= ACCEPT;
      wr_addr      <= '0;
      cm_addr      <= '0;
      rd_addr      <= '0;
      o_drop       <= 1'b0;
      o_drop_count <= '0;
    end else begin
      state   <= state_nx;
      wr_addr <= wr_nx;
      cm_addr <= cm_nx;
      rd_addr <= rd_addr + {{LGFLEN{1'b0}}, w_rd};
      o_drop  <= drop_nx;
      if (drop_nx) o_drop_count <= sat_inc(o_drop_count);
    end
  end

  sfifo_pkt_mem #(
    .BW     (BW),
    .LGFLEN (LGFLEN)
  ) u_mem (
    .clk     (i_clk),
    .we      (mem_we),
    .wr_idx  (wr_addr[LGFLEN-1:0]),
    .wr_word ({i_last, i_data}),
    .rd_idx  (rd_addr[LGFLEN-1:0]),
    .rd_word (head)
  );

  assign o_data = head[BW-1:0];
  assign o_last = head[BW];

endmodule

// File: tb/tb_sfifo_pkt.sv
// Bench for sfifo_pkt: directed and random traffic against a queue-based packet model.
module tb_sfifo_pkt;
  localparam int BW = 16, LGFLEN = 4, DCW = 16, FLEN = 16;

  logic              i_clk = 1'b0, i_reset_n = 1'b0;
  logic              i_wr = 1'b0, i_last = 1'b0, i_abort = 1'b0, i_rd = 1'b0;
  logic [BW-1:0]     i_data = '0;
  logic [LGFLEN:0]   i_af_level = 5'd12, i_ae_level = 5'd2;
  logic              o_full, o_almost_full, o_drop, o_last, o_empty, o_almost_empty;
  logic [LGFLEN:0]   o_space, o_fill;
  logic [DCW-1:0]    o_drop_count;
  logic [BW-1:0]     o_data;

  int n_cmp = 0, n_err = 0;

  // Model: committed words visible to the reader, and the packet being written
  logic [BW:0] cq[$];
  logic [BW:0] pq[$];
  bit          dropping, m_drop;
  int          m_cnt;

  sfifo_pkt #(.BW(BW), .LGFLEN(LGFLEN), .DCW(DCW)) dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_wr(i_wr), .i_data(i_data),
    .i_last(i_last), .i_abort(i_abort), .i_af_level(i_af_level),
    .i_ae_level(i_ae_level), .o_full(o_full), .o_space(o_space),
    .o_almost_full(o_almost_full), .o_drop(o_drop), .o_drop_count(o_drop_count),
    .i_rd(i_rd), .o_data(o_data), .o_last(o_last), .o_empty(o_empty),
    .o_fill(o_fill), .o_almost_empty(o_almost_empty)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    cq.delete();
    pq.delete();
    dropping = 1'b0;
    m_drop   = 1'b0;
    m_cnt    = 0;
  endtask

  task automatic check_all(input string where);
    int used;
    used = cq.size() + pq.size();
    chk({where, ":empty"},        32'(o_empty),        32'(cq.size() == 0));
    chk({where, ":fill"},         32'(o_fill),         32'(cq.size()));
    chk({where, ":space"},        32'(o_space),        32'(FLEN - used));
    chk({where, ":full"},         32'(o_full),         32'(used == FLEN));
    chk({where, ":almost_full"},  32'(o_almost_full),  32'(used >= int'(i_af_level)));
    chk({where, ":almost_empty"}, 32'(o_almost_empty), 32'(cq.size() <= int'(i_ae_level)));
    chk({where, ":drop"},         32'(o_drop),         32'(m_drop));
    chk({where, ":drop_count"},   32'(o_drop_count),   32'(m_cnt));
    if (cq.size() != 0) begin
      chk({where, ":data"}, 32'(o_data), 32'(cq[0][BW-1:0]));
      chk({where, ":last"}, 32'(o_last), 32'(cq[0][BW]));
    end
  endtask

  // Packet-level rules: space is judged before this cycle's read, abort wins over write
  task automatic model_step();
    bit full;
    full   = (cq.size() + pq.size()) == FLEN;
    m_drop = 1'b0;
    if (i_rd && cq.size() != 0) void'(cq.pop_front());
    if (i_abort) begin
      pq.delete();
      dropping = 1'b0;
    end else if (!dropping) begin
      if (i_wr && !full) begin
        pq.push_back({i_last, i_data});
        if (i_last) begin
          foreach (pq[k]) cq.push_back(pq[k]);
          pq.delete();
        end
      end else if (i_wr) begin
        pq.delete();
        if (i_last) m_drop = 1'b1;
        else        dropping = 1'b1;
      end
    end else if (i_wr && i_last) begin
      m_drop   = 1'b1;
      dropping = 1'b0;
    end
    if (m_drop && m_cnt != 65535) m_cnt++;
  endtask

  task automatic cycle(input string where, input bit wr, input logic [BW-1:0] d,
                       input bit last, input bit abort, input bit rd);
    i_wr = wr; i_data = d; i_last = last; i_abort = abort; i_rd = rd;
    #1;
    check_all(where);
    model_step();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic write_pkt(input string where, input int n, input logic [BW-1:0] base);
    for (int i = 0; i < n; i++) cycle(where, 1'b1, base + BW'(i), i == n - 1, 1'b0, 1'b0);
  endtask

  task automatic read_n(input string where, input int n);
    for (int i = 0; i < n; i++) cycle(where, 1'b0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    model_reset();
    @(negedge i_clk);
    @(negedge i_clk);
    #1 check_all("reset");
    @(negedge i_clk);
    i_reset_n = 1'b1;

    // Three-word packet, then read it back
    write_pkt("pkt3", 3, 16'h0001);
    cycle("pkt3_idle", 1'b0, '0, 1'b0, 1'b0, 1'b0);
    read_n("pkt3_rd", 3);

    // Partial packet rolled back by abort, then a clean two-word packet
    for (int i = 0; i < 5; i++) cycle("abort_wr", 1'b1, 16'h0A00 + 16'(i), 1'b0, 1'b0, 1'b0);
    cycle("abort", 1'b1, 16'hDEAD, 1'b0, 1'b1, 1'b0);
    write_pkt("after_abort", 2, 16'h0B00);
    read_n("after_abort_rd", 3);

    // Oversized packet into an empty FIFO
    write_pkt("oversize", 20, 16'h2000);
    cycle("oversize_drop", 1'b0, '0, 1'b0, 1'b0, 1'b0);
    cycle("oversize_post", 1'b0, '0, 1'b0, 1'b0, 1'b0);

    // Concurrent write and drain across pointer wrap
    write_pkt("p10a", 10, 16'h3000);
    for (int i = 0; i < 10; i++) cycle("p10b", 1'b1, 16'h4000 + 16'(i), i == 9, 1'b0, 1'b1);
    read_n("p10_drain", 11);

    // Threshold flags
    write_pkt("af", 12, 16'h5000);
    read_n("ae", 11);

    // Random traffic with random static thresholds
    for (int r = 0; r < 3; r++) begin
      i_af_level = 5'($urandom_range(0, 16));
      i_ae_level = 5'($urandom_range(0, 16));
      for (int i = 0; i < 250; i++) begin
        cycle("rand", ($urandom % 4) != 0, 16'($urandom), ($urandom % 6) == 0,
              ($urandom % 30) == 0, ($urandom % (r + 2)) == 0);
      end
      read_n("rand_drain", 17);
    end
    i_af_level = 5'd12;
    i_ae_level = 5'd2;

    // Asynchronous reset with committed data and a packet in flight
    write_pkt("pre_rst", 4, 16'h6000);
    cycle("pre_rst_part", 1'b1, 16'h6100, 1'b0, 1'b0, 1'b0);
    i_wr = 1'b1; i_data = 16'h6101; i_last = 1'b0; i_abort = 1'b0; i_rd = 1'b0;
    #2 i_reset_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge i_clk);
    i_wr = 1'b0;
    i_reset_n = 1'b1;
    write_pkt("post_rst", 1, 16'h7777);
    read_n("post_rst_rd", 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
